trn_axi_user_bridge: RTL and testbench

//  User-side counterpart of the PCIe TRN<->AXI shim: lets legacy TRN-style application logic
//  (sof/eof/rem framing) drive the core's AXI-stream TX port and consume its AXI-stream RX port.

---
 rtl/trn_axi_pkg.sv | 26 ++
 rtl/trn_axi_skid.sv | 73 +++++++
 rtl/trn_axi_user_bridge.sv | 231 +++++++++++++++++++++++
 tb/tb_trn_axi_user_bridge.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trn_axi_pkg.sv
// Shared definitions for the TRN <-> AXI user-side bridge: tuser bit
// positions on both AXI directions and the packet-framing FSM state type.
package trn_axi_pkg;

    // AXI TX tuser bit positions
    localparam int TX_DSC    = 3;
    localparam int TX_STR    = 2;
    localparam int TX_ERRFWD = 1;
    localparam int TX_ECRC   = 0;

    // AXI RX tuser bit positions
    localparam int RX_ERRFWD = 1;
    localparam int RX_BAR_LO = 2;
    localparam int RX_BAR_HI = 8;

    localparam int TX_USER_W = 4;
    localparam int RX_USER_W = 22;
    localparam int BAR_W     = RX_BAR_HI - RX_BAR_LO + 1;

    // Packet framing state, shared by the TX and RX trackers
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } trn_fsm_e;

endpackage

// File: rtl/trn_axi_skid.sv
// Two-entry registered skid buffer. in_ready is a flop that is high while
// fewer than two entries are held; out_valid/out_data come straight from
// storage, so no combinational path exists from inputs to outputs.
// Handshake: a beat moves when valid and ready are both high at a rising
// clock edge; a producer keeps valid and data stable until that happens.
module trn_axi_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [1:0]   count;
    logic [1:0]   count_nxt;
    logic [W-1:0] ent0;
    logic [W-1:0] ent1;
    logic         push;
    logic         pop;

    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_valid = (count != 2'd0);
    assign out_data  = ent0;

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    // Storage, occupancy and registered ready; ent0 is always the head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= 2'd0;
            in_ready <= 1'b0;
            ent0     <= '0;
            ent1     <= '0;
        end else begin
            count    <= count_nxt;
            in_ready <= (count_nxt < 2'd2);
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) ent0 <= in_data;
                    else               ent1 <= in_data;
                end
                2'b01: begin
                    ent0 <= ent1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        ent0 <= in_data;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= in_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/trn_axi_user_bridge.sv
// Legacy TRN-style application framing (sof/eof/rem) onto the core's AXI
// stream user ports, one trn_axi_skid per direction.
// TX: a framing FSM polices sof/eof; orphan beats are dropped, and a sof or
// discontinue inside a packet closes it with tlast and tuser src_dsc.
// RX: sof is regenerated from tlast of the previously delivered beat.
// Optional build macro TRN_AXI_PERF_CNT_EN adds saturating packet counters.
module trn_axi_user_bridge
    import trn_axi_pkg::*;
#(
    parameter int C_DATA_WIDTH = 64,
    parameter int REM_WIDTH    = 1,
    parameter int STRB_WIDTH   = C_DATA_WIDTH / 8
) (
    input  logic                    user_clk,
    input  logic                    user_rst_n,
    // legacy TX
    input  logic [C_DATA_WIDTH-1:0] usr_td,
    input  logic                    usr_tsof,
    input  logic                    usr_teof,
    input  logic [REM_WIDTH-1:0]    usr_trem,
    input  logic                    usr_tsrc_rdy,
    output logic                    usr_tdst_rdy,
    input  logic                    usr_tsrc_dsc,
    input  logic                    usr_terrfwd,
    input  logic                    usr_tstr,
    input  logic                    usr_tecrc_gen,
    // AXI TX to core
    output logic [C_DATA_WIDTH-1:0] m_axis_tx_tdata,
    output logic [STRB_WIDTH-1:0]   m_axis_tx_tkeep,
    output logic                    m_axis_tx_tlast,
    output logic                    m_axis_tx_tvalid,
    input  logic                    m_axis_tx_tready,
    output logic [TX_USER_W-1:0]    m_axis_tx_tuser,
    // AXI RX from core
    input  logic [C_DATA_WIDTH-1:0] s_axis_rx_tdata,
    input  logic [STRB_WIDTH-1:0]   s_axis_rx_tkeep,
    input  logic                    s_axis_rx_tlast,
    input  logic                    s_axis_rx_tvalid,
    output logic                    s_axis_rx_tready,
    input  logic [RX_USER_W-1:0]    s_axis_rx_tuser,
    // legacy RX
    output logic [C_DATA_WIDTH-1:0] usr_rd,
    output logic                    usr_rsof,
    output logic                    usr_reof,
    output logic [REM_WIDTH-1:0]    usr_rrem,
    output logic                    usr_rsrc_rdy,
    input  logic                    usr_rdst_rdy,
    output logic                    usr_rerrfwd,
    output logic [BAR_W-1:0]        usr_rbar_hit,
    // debug visibility of the framing FSMs
    output trn_fsm_e                tx_fsm_dbg,
    output trn_fsm_e                rx_fsm_dbg,
    output logic                    proto_err
`ifdef TRN_AXI_PERF_CNT_EN
    ,
    output logic [15:0]             tx_pkt_cnt,
    output logic [15:0]             rx_pkt_cnt
`endif
);

    localparam int TX_PW = TX_USER_W + 1 + STRB_WIDTH + C_DATA_WIDTH;
    localparam int RX_PW = 1 + BAR_W + 1 + STRB_WIDTH + C_DATA_WIDTH;

    // ------------------------------------------------------------------ TX
    trn_fsm_e                tx_state;
    trn_fsm_e                tx_state_nxt;
    logic                    tx_accept;
    logic                    tx_drop;
    logic                    tx_force_last;
    logic                    tx_dsc_out;
    logic                    tx_set_err;
    logic                    tx_in_ready;
    logic [STRB_WIDTH-1:0]   tx_tkeep;
    logic [TX_USER_W-1:0]    tx_tuser;
    logic [TX_PW-1:0]        tx_in_data;
    logic [TX_PW-1:0]        tx_out_data;

    assign usr_tdst_rdy = tx_in_ready;
    assign tx_accept    = usr_tsrc_rdy & tx_in_ready;
    assign tx_fsm_dbg   = tx_state;

    // TX framing state register
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) tx_state <= IDLE;
        else             tx_state <= tx_state_nxt;
    end

    // TX next state: only an accepted beat moves the FSM
    always_comb begin
        tx_state_nxt = tx_state;
        if (tx_accept) begin
            case (tx_state)
                IDLE:    if (usr_tsof && !usr_teof && !usr_tsrc_dsc) tx_state_nxt = IN_PKT;
                IN_PKT:  if (usr_tsof || usr_teof || usr_tsrc_dsc)   tx_state_nxt = IDLE;
                default: tx_state_nxt = IDLE;
            endcase
        end
    end

    // TX per-beat decisions: drop orphans, force-close corrupt packets
    always_comb begin
        tx_drop       = 1'b0;
        tx_force_last = 1'b0;
        tx_dsc_out    = usr_tsrc_dsc;
        tx_set_err    = 1'b0;
        case (tx_state)
            IDLE: begin
                if (!usr_tsof) begin
                    tx_drop    = 1'b1;
                    tx_set_err = 1'b1;
                end else if (usr_tsrc_dsc) begin
                    tx_force_last = 1'b1;
                end
            end
            IN_PKT: begin
                if (usr_tsof) begin
                    tx_force_last = 1'b1;
                    tx_dsc_out    = 1'b1;
                    tx_set_err    = 1'b1;
                end else if (usr_tsrc_dsc) begin
                    tx_force_last = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // TX tuser assembly from the legacy side-band bits
    always_comb begin
        tx_tuser            = '0;
        tx_tuser[TX_DSC]    = tx_dsc_out;
        tx_tuser[TX_STR]    = usr_tstr;
        tx_tuser[TX_ERRFWD] = usr_terrfwd;
        tx_tuser[TX_ECRC]   = usr_tecrc_gen;
    end

    // rem selects full or lower-half bytes; a 32-bit beat is always full
    if (C_DATA_WIDTH == 64) begin : g_keep64
        assign tx_tkeep = usr_trem[0] ? {STRB_WIDTH{1'b1}}
                                      : {{(STRB_WIDTH/2){1'b0}}, {(STRB_WIDTH/2){1'b1}}};
    end else begin : g_keep32
        assign tx_tkeep = {STRB_WIDTH{1'b1}};
    end

    assign tx_in_data = {tx_tuser, (usr_teof | tx_force_last), tx_tkeep, usr_td};

    trn_axi_skid #(.W(TX_PW)) u_tx_skid (
        .clk       (user_clk),
        .rst_n     (user_rst_n),
        .in_valid  (usr_tsrc_rdy & ~tx_drop),
        .in_ready  (tx_in_ready),
        .in_data   (tx_in_data),
        .out_valid (m_axis_tx_tvalid),
        .out_ready (m_axis_tx_tready),
        .out_data  (tx_out_data)
    );

    assign {m_axis_tx_tuser, m_axis_tx_tlast, m_axis_tx_tkeep, m_axis_tx_tdata} = tx_out_data;

    // Sticky framing error, only reset clears it
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n)                  proto_err <= 1'b0;
        else if (tx_accept && tx_set_err) proto_err <= 1'b1;
    end

    // ------------------------------------------------------------------ RX
    trn_fsm_e                rx_state;
    trn_fsm_e                rx_state_nxt;
    logic                    rx_pop;
    logic                    rx_last;
    logic [STRB_WIDTH-1:0]   rx_keep;
    logic [RX_PW-1:0]        rx_in_data;
    logic [RX_PW-1:0]        rx_out_data;
    logic                    rx_unused;

    assign rx_unused  = ^{s_axis_rx_tuser[RX_USER_W-1:RX_BAR_HI+1], s_axis_rx_tuser[0], usr_trem};
    assign rx_in_data = {s_axis_rx_tuser[RX_ERRFWD], s_axis_rx_tuser[RX_BAR_HI:RX_BAR_LO],
                         s_axis_rx_tlast, s_axis_rx_tkeep, s_axis_rx_tdata};

    trn_axi_skid #(.W(RX_PW)) u_rx_skid (
        .clk       (user_clk),
        .rst_n     (user_rst_n),
        .in_valid  (s_axis_rx_tvalid),
        .in_ready  (s_axis_rx_tready),
        .in_data   (rx_in_data),
        .out_valid (usr_rsrc_rdy),
        .out_ready (usr_rdst_rdy),
        .out_data  (rx_out_data)
    );

    assign {usr_rerrfwd, usr_rbar_hit, rx_last, rx_keep, usr_rd} = rx_out_data;
    assign usr_reof   = rx_last;
    assign usr_rrem   = REM_WIDTH'(|rx_keep[STRB_WIDTH-1:STRB_WIDTH/2]);
    assign rx_pop     = usr_rsrc_rdy & usr_rdst_rdy;
    assign rx_fsm_dbg = rx_state;

    // RX framing state register
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) rx_state <= IDLE;
        else             rx_state <= rx_state_nxt;
    end

    // RX next state: a delivered tlast beat re-arms sof
    always_comb begin
        rx_state_nxt = rx_state;
        if (rx_pop) rx_state_nxt = rx_last ? IDLE : IN_PKT;
    end

    // RX output: sof marks the head beat while between packets
    always_comb begin
        usr_rsof = 1'b0;
        if (usr_rsrc_rdy && rx_state == IDLE) usr_rsof = 1'b1;
    end

`ifdef TRN_AXI_PERF_CNT_EN
    // Saturating counts of completed packets on each AXI side
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            tx_pkt_cnt <= 16'h0000;
            rx_pkt_cnt <= 16'h0000;
        end else begin
            if (m_axis_tx_tvalid && m_axis_tx_tready && m_axis_tx_tlast && tx_pkt_cnt != 16'hFFFF)
                tx_pkt_cnt <= tx_pkt_cnt + 16'h0001;
            if (s_axis_rx_tvalid && s_axis_rx_tready && s_axis_rx_tlast && rx_pkt_cnt != 16'hFFFF)
                rx_pkt_cnt <= rx_pkt_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_trn_axi_user_bridge.sv
// Directed bench for trn_axi_user_bridge (default build, 64-bit datapath).
module tb_trn_axi_user_bridge;
    import trn_axi_pkg::*;

    localparam int DW = 64;
    localparam int SW = 8;

    // ---------------------------------------------------------- clock/reset
    logic user_clk   = 1'b0;
    logic user_rst_n = 1'b0;
    always #5 user_clk = ~user_clk;

    logic [DW-1:0] usr_td;
    logic          usr_tsof, usr_teof, usr_tsrc_rdy, usr_tdst_rdy;
    logic [0:0]    usr_trem;
    logic          usr_tsrc_dsc, usr_terrfwd, usr_tstr, usr_tecrc_gen;
    logic [DW-1:0] m_axis_tx_tdata;
    logic [SW-1:0] m_axis_tx_tkeep;
    logic          m_axis_tx_tlast, m_axis_tx_tvalid, m_axis_tx_tready;
    logic [3:0]    m_axis_tx_tuser;
    logic [DW-1:0] s_axis_rx_tdata;
    logic [SW-1:0] s_axis_rx_tkeep;
    logic          s_axis_rx_tlast, s_axis_rx_tvalid, s_axis_rx_tready;
    logic [21:0]   s_axis_rx_tuser;
    logic [DW-1:0] usr_rd;
    logic          usr_rsof, usr_reof, usr_rsrc_rdy, usr_rdst_rdy, usr_rerrfwd;
    logic [0:0]    usr_rrem;
    logic [6:0]    usr_rbar_hit;
    trn_fsm_e      tx_fsm_dbg, rx_fsm_dbg;
    logic          proto_err;

    trn_axi_user_bridge dut (
        .user_clk         (user_clk),
        .user_rst_n       (user_rst_n),
        .usr_td           (usr_td),
        .usr_tsof         (usr_tsof),
        .usr_teof         (usr_teof),
        .usr_trem         (usr_trem),
        .usr_tsrc_rdy     (usr_tsrc_rdy),
        .usr_tdst_rdy     (usr_tdst_rdy),
        .usr_tsrc_dsc     (usr_tsrc_dsc),
        .usr_terrfwd      (usr_terrfwd),
        .usr_tstr         (usr_tstr),
        .usr_tecrc_gen    (usr_tecrc_gen),
        .m_axis_tx_tdata  (m_axis_tx_tdata),
        .m_axis_tx_tkeep  (m_axis_tx_tkeep),
        .m_axis_tx_tlast  (m_axis_tx_tlast),
        .m_axis_tx_tvalid (m_axis_tx_tvalid),
        .m_axis_tx_tready (m_axis_tx_tready),
        .m_axis_tx_tuser  (m_axis_tx_tuser),
        .s_axis_rx_tdata  (s_axis_rx_tdata),
        .s_axis_rx_tkeep  (s_axis_rx_tkeep),
        .s_axis_rx_tlast  (s_axis_rx_tlast),
        .s_axis_rx_tvalid (s_axis_rx_tvalid),
        .s_axis_rx_tready (s_axis_rx_tready),
        .s_axis_rx_tuser  (s_axis_rx_tuser),
        .usr_rd           (usr_rd),
        .usr_rsof         (usr_rsof),
        .usr_reof         (usr_reof),
        .usr_rrem         (usr_rrem),
        .usr_rsrc_rdy     (usr_rsrc_rdy),
        .usr_rdst_rdy     (usr_rdst_rdy),
        .usr_rerrfwd      (usr_rerrfwd),
        .usr_rbar_hit     (usr_rbar_hit),
        .tx_fsm_dbg       (tx_fsm_dbg),
        .rx_fsm_dbg       (rx_fsm_dbg),
        .proto_err        (proto_err)
    );

    // ---------------------------------------------------------- checking
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------------- scoreboard
    logic [76:0] tx_exp_q[$];
    logic [76:0] tx_got_q[$];
    logic [74:0] rx_exp_q[$];
    logic [74:0] rx_got_q[$];

    function automatic logic [76:0] tx_b(input logic [3:0] u, input logic l,
                                         input logic [7:0] k, input logic [63:0] d);
        return {u, l, k, d};
    endfunction

    function automatic logic [74:0] rx_b(input logic sof, input logic eof, input logic rem,
                                         input logic err, input logic [6:0] bar,
                                         input logic [63:0] d);
        return {sof, eof, rem, err, bar, d};
    endfunction

    // capture every transfer on both output sides, mid-cycle
    always @(negedge user_clk) begin
        if (user_rst_n && m_axis_tx_tvalid && m_axis_tx_tready)
            tx_got_q.push_back({m_axis_tx_tuser, m_axis_tx_tlast, m_axis_tx_tkeep, m_axis_tx_tdata});
        if (user_rst_n && usr_rsrc_rdy && usr_rdst_rdy)
            rx_got_q.push_back({usr_rsof, usr_reof, usr_rrem, usr_rerrfwd, usr_rbar_hit, usr_rd});
    end

    // occupancy model for the TX skid while tready toggles
    logic mdl_en  = 1'b0;
    int   mdl_cnt = 0;
    always @(negedge user_clk) begin
        if (mdl_en) begin
            check_eq("t2_tdst_rdy", usr_tdst_rdy, (mdl_cnt < 2));
            check_eq("t2_tvalid", m_axis_tx_tvalid, (mdl_cnt > 0));
            mdl_cnt = mdl_cnt + int'(usr_tsrc_rdy && usr_tdst_rdy)
                              - int'(m_axis_tx_tvalid && m_axis_tx_tready);
        end
    end

    task automatic cmp_tx(input string tag);
        check_eq({tag, "_count"}, tx_got_q.size(), tx_exp_q.size());
        for (int i = 0; i < tx_exp_q.size() && i < tx_got_q.size(); i++)
            check_eq($sformatf("%s_beat%0d", tag, i), tx_got_q[i], tx_exp_q[i]);
        tx_got_q.delete();
        tx_exp_q.delete();
    endtask

    task automatic cmp_rx(input string tag);
        check_eq({tag, "_count"}, rx_got_q.size(), rx_exp_q.size());
        for (int i = 0; i < rx_exp_q.size() && i < rx_got_q.size(); i++)
            check_eq($sformatf("%s_beat%0d", tag, i), rx_got_q[i], rx_exp_q[i]);
        rx_got_q.delete();
        rx_exp_q.delete();
    endtask

    // ---------------------------------------------------------- drivers
    task automatic idle(input int n);
        repeat (n) @(posedge user_clk);
        #1;
    endtask

    // flags = {str, errfwd, ecrc}
    task automatic tx_send(input logic [63:0] d, input logic sof, input logic eof,
                           input logic rem, input logic dsc, input logic [2:0] flags);
        int   budget;
        logic took;
        budget        = 200;
        took          = 1'b0;
        usr_td        = d;
        usr_tsof      = sof;
        usr_teof      = eof;
        usr_trem      = rem;
        usr_tsrc_dsc  = dsc;
        usr_tstr      = flags[2];
        usr_terrfwd   = flags[1];
        usr_tecrc_gen = flags[0];
        usr_tsrc_rdy  = 1'b1;
        while (!took && budget > 0) begin
            @(negedge user_clk);
            took = usr_tdst_rdy;
            @(posedge user_clk);
            #1;
            budget--;
        end
        usr_tsrc_rdy = 1'b0;
        check_eq("tx_accepted", took, 1'b1);
    endtask

    task automatic rx_send(input logic [63:0] d, input logic [7:0] k, input logic l,
                           input logic [21:0] u);
        int   budget;
        logic took;
        budget           = 200;
        took             = 1'b0;
        s_axis_rx_tdata  = d;
        s_axis_rx_tkeep  = k;
        s_axis_rx_tlast  = l;
        s_axis_rx_tuser  = u;
        s_axis_rx_tvalid = 1'b1;
        while (!took && budget > 0) begin
            @(negedge user_clk);
            took = s_axis_rx_tready;
            @(posedge user_clk);
            #1;
            budget--;
        end
        s_axis_rx_tvalid = 1'b0;
        check_eq("rx_accepted", took, 1'b1);
    endtask

    task automatic do_reset();
        user_rst_n = 1'b0;
        repeat (3) @(posedge user_clk);
        #1;
        user_rst_n = 1'b1;
        idle(2);
    endtask

    // ---------------------------------------------------------- watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------- stimulus
    initial begin
        usr_td = '0; usr_tsof = 0; usr_teof = 0; usr_trem = 0; usr_tsrc_rdy = 0;
        usr_tsrc_dsc = 0; usr_terrfwd = 0; usr_tstr = 0; usr_tecrc_gen = 0;
        m_axis_tx_tready = 1'b1;
        s_axis_rx_tdata = '0; s_axis_rx_tkeep = '0; s_axis_rx_tlast = 0;
        s_axis_rx_tvalid = 0; s_axis_rx_tuser = '0;
        usr_rdst_rdy = 1'b1;

        // reset values while reset is held
        user_rst_n = 1'b0;
        repeat (3) @(posedge user_clk);
        #1;
        check_eq("rst_tx_tvalid", m_axis_tx_tvalid, 1'b0);
        check_eq("rst_tx_tlast", m_axis_tx_tlast, 1'b0);
        check_eq("rst_tx_tdata", m_axis_tx_tdata, 64'h0);
        check_eq("rst_tdst_rdy", usr_tdst_rdy, 1'b0);
        check_eq("rst_rx_tready", s_axis_rx_tready, 1'b0);
        check_eq("rst_rsrc_rdy", usr_rsrc_rdy, 1'b0);
        check_eq("rst_rsof", usr_rsof, 1'b0);
        check_eq("rst_reof", usr_reof, 1'b0);
        check_eq("rst_rd", usr_rd, 64'h0);
        check_eq("rst_proto_err", proto_err, 1'b0);
        user_rst_n = 1'b1;
        idle(2);
        check_eq("post_rst_tdst_rdy", usr_tdst_rdy, 1'b1);

        // 1) three-beat packet, last beat lower half only
        tx_send(64'hD000_0000_0000_0000, 1, 0, 1, 0, 3'b000);
        check_eq("t1_latency_tvalid", m_axis_tx_tvalid, 1'b1);
        check_eq("t1_latency_tdata", m_axis_tx_tdata, 64'hD000_0000_0000_0000);
        tx_send(64'hD000_0000_0000_0001, 0, 0, 1, 0, 3'b000);
        tx_send(64'hD000_0000_0000_0002, 0, 1, 0, 0, 3'b000);
        tx_exp_q.push_back(tx_b(4'b0000, 0, 8'hFF, 64'hD000_0000_0000_0000));
        tx_exp_q.push_back(tx_b(4'b0000, 0, 8'hFF, 64'hD000_0000_0000_0001));
        tx_exp_q.push_back(tx_b(4'b0000, 1, 8'h0F, 64'hD000_0000_0000_0002));
        idle(3);
        cmp_tx("t1");

        // single-beat packet carrying errfwd and ecrc side-band
        tx_send(64'h0000_0000_0000_0D03, 1, 1, 1, 0, 3'b011);
        tx_exp_q.push_back(tx_b(4'b0011, 1, 8'hFF, 64'h0000_0000_0000_0D03));
        // discontinue mid-packet, then a clean single-beat packet
        tx_send(64'h0000_0000_0000_0D04, 1, 0, 1, 0, 3'b000);
        tx_send(64'h0000_0000_0000_0D05, 0, 0, 1, 1, 3'b000);
        tx_send(64'h0000_0000_0000_0D06, 1, 1, 0, 0, 3'b100);
        tx_exp_q.push_back(tx_b(4'b0000, 0, 8'hFF, 64'h0000_0000_0000_0D04));
        tx_exp_q.push_back(tx_b(4'b1000, 1, 8'hFF, 64'h0000_0000_0000_0D05));
        tx_exp_q.push_back(tx_b(4'b0100, 1, 8'h0F, 64'h0000_0000_0000_0D06));
        idle(3);
        cmp_tx("t_dsc");
        check_eq("t_dsc_proto_err", proto_err, 1'b0);

        // 2) ten-beat packet against tready toggling 1010 for 20 clocks
        mdl_cnt = 0;
        mdl_en  = 1'b1;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    m_axis_tx_tready = (i % 2 == 0);
                    @(posedge user_clk);
                    #1;
                end
                m_axis_tx_tready = 1'b1;
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    tx_send(64'hA0 + 64'(i), (i == 0), (i == 9), 1, 0, 3'b000);
                    tx_exp_q.push_back(tx_b(4'b0000, (i == 9), 8'hFF, 64'hA0 + 64'(i)));
                end
            end
        join
        m_axis_tx_tready = 1'b1;
        idle(6);
        mdl_en = 1'b0;
        cmp_tx("t2");
        check_eq("t2_proto_err", proto_err, 1'b0);

        // 4) sof inside a packet closes it as discontinued
        tx_send(64'h0000_0000_0000_0E07, 1, 0, 1, 0, 3'b000);
        check_eq("t4_proto_err_before", proto_err, 1'b0);
        tx_send(64'h0000_0000_0000_0E08, 1, 0, 1, 0, 3'b000);
        check_eq("t4_proto_err_after", proto_err, 1'b1);
        tx_exp_q.push_back(tx_b(4'b0000, 0, 8'hFF, 64'h0000_0000_0000_0E07));
        tx_exp_q.push_back(tx_b(4'b1000, 1, 8'hFF, 64'h0000_0000_0000_0E08));
        idle(3);
        cmp_tx("t4");

        do_reset();
        check_eq("reset_clears_proto_err", proto_err, 1'b0);

        // 3) orphan beat in IDLE is swallowed and flags the error
        tx_send(64'h0000_0000_0000_0F09, 0, 0, 1, 0, 3'b000);
        check_eq("t3_proto_err_next", proto_err, 1'b1);
        idle(4);
        check_eq("t3_proto_err_sticky", proto_err, 1'b1);
        cmp_tx("t3_dropped");
        tx_send(64'h0000_0000_0000_0F0A, 1, 1, 1, 0, 3'b000);
        tx_exp_q.push_back(tx_b(4'b0000, 1, 8'hFF, 64'h0000_0000_0000_0F0A));
        idle(3);
        cmp_tx("t3_recover");
        check_eq("t3_proto_err_final", proto_err, 1'b1);

        // 5) RX: 2-beat then 1-beat packet, then a half beat with errfwd
        rx_send(64'h5000_0000_0000_0000, 8'hFF, 0, 22'h000004);
        rx_send(64'h5000_0000_0000_0001, 8'hFF, 1, 22'h000004);
        rx_send(64'h5000_0000_0000_0002, 8'hFF, 1, 22'h000004);
        rx_send(64'h5000_0000_0000_0003, 8'h0F, 1, 22'h000102);
        rx_exp_q.push_back(rx_b(1, 0, 1, 0, 7'h01, 64'h5000_0000_0000_0000));
        rx_exp_q.push_back(rx_b(0, 1, 1, 0, 7'h01, 64'h5000_0000_0000_0001));
        rx_exp_q.push_back(rx_b(1, 1, 1, 0, 7'h01, 64'h5000_0000_0000_0002));
        rx_exp_q.push_back(rx_b(1, 1, 0, 1, 7'h40, 64'h5000_0000_0000_0003));
        idle(3);
        cmp_rx("t5");

        // 6) reset in the middle of an RX packet
        rx_send(64'h6000_0000_0000_0004, 8'hFF, 0, 22'h000004);
        idle(2);
        rx_exp_q.push_back(rx_b(1, 0, 1, 0, 7'h01, 64'h6000_0000_0000_0004));
        cmp_rx("t6_first");
        usr_rdst_rdy = 1'b0;
        rx_send(64'h6000_0000_0000_0005, 8'hFF, 0, 22'h000004);
        check_eq("t6_held_rsrc_rdy", usr_rsrc_rdy, 1'b1);
        check_eq("t6_held_rsof", usr_rsof, 1'b0);
        check_eq("t6_held_rd", usr_rd, 64'h6000_0000_0000_0005);
        user_rst_n = 1'b0;
        #1;
        check_eq("t6_rst_rsrc_rdy", usr_rsrc_rdy, 1'b0);
        check_eq("t6_rst_rd", usr_rd, 64'h0);
        check_eq("t6_rst_rsof", usr_rsof, 1'b0);
        check_eq("t6_rst_reof", usr_reof, 1'b0);
        check_eq("t6_rst_rx_tready", s_axis_rx_tready, 1'b0);
        idle(2);
        user_rst_n = 1'b1;
        idle(2);
        usr_rdst_rdy = 1'b1;
        rx_send(64'h6000_0000_0000_0006, 8'hFF, 0, 22'h000004);
        idle(2);
        rx_exp_q.push_back(rx_b(1, 0, 1, 0, 7'h01, 64'h6000_0000_0000_0006));
        cmp_rx("t6_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
